// File: rtl/bids22_host_pkg.sv
// Shared opcodes, FSM states and failure codes for the bids22 controller host.
package bids22_host_pkg;

   typedef enum logic [3:0] {
      NOOP   = 4'b0000,
      UNLOCK = 4'b0001,
      LOCK   = 4'b0010,
      LOADX  = 4'b0011,
      LOADY  = 4'b0100,
      LOADZ  = 4'b0101
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAITRDY,
      S_CHECK,
      S_ROUND,
      S_WAITOVER,
      S_DONE,
      S_FAIL
   } state_e;

   localparam logic [1:0] FC_NONE    = 2'd0;
   localparam logic [1:0] FC_CMDERR  = 2'd1;
   localparam logic [1:0] FC_OVERTMO = 2'd2;
   localparam logic [1:0] FC_RDYTMO  = 2'd3;

   // Opcode issued at each sequence step: 0 unlock, 1-3 balance loads, 4 relock.
   function automatic op_e step_op(input logic [2:0] step);
      case (step)
         3'd0:    return UNLOCK;
         3'd1:    return LOADX;
         3'd2:    return LOADY;
         3'd3:    return LOADZ;
         default: return LOCK;
      endcase
   endfunction

endpackage

// File: rtl/bids22_ctrl_host_if.sv
// Command/round bus between the controller host (master) and the bids22 core (slave).
interface bids22_ctrl_host_if;

   logic [3:0]  C_op;
   logic [31:0] C_data;
   logic        C_start;
   logic        ready;
   logic [2:0]  err;
   logic        roundOver;
   logic [31:0] maxBid;

   modport master (
      output C_op, C_data, C_start,
      input  ready, err, roundOver, maxBid
   );

   modport slave (
      input  C_op, C_data, C_start,
      output ready, err, roundOver, maxBid
   );

endinterface

// File: rtl/bids22_host_tmo.sv
// Loadable down-counter; expired is high once TMO_CYC cycles have elapsed since load.
module bids22_host_tmo #(
   parameter int unsigned TMO_CYC = 1024,
   parameter int unsigned TMO_W   = 11
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   output logic expired
);

   logic [TMO_W-1:0] cnt;

   // Reload on request, otherwise count down and hold at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= TMO_W'(TMO_CYC - 1);
      end else if (cnt != '0) begin
         cnt <= cnt - TMO_W'(1);
      end
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/bids22_ctrl_host.sv
// Controller-side initiator: runs unlock, balance loads, a timed round and relock
// against the bids22 core from a single go pulse.
module bids22_ctrl_host
   import bids22_host_pkg::*;
#(
   parameter int unsigned RND_W   = 16,
   parameter int unsigned TMO_CYC = 1024,
   parameter int unsigned TMO_W   = 11
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      go,
   input  logic [31:0]               cfg_key,
   input  logic [31:0]               cfg_x_bal,
   input  logic [31:0]               cfg_y_bal,
   input  logic [31:0]               cfg_z_bal,
   input  logic [RND_W-1:0]          cfg_round_cycles,
   bids22_ctrl_host_if.master        bus,
   output logic                      busy,
   output logic                      done,
   output logic                      fail,
   output logic [1:0]                fail_code,
   output logic [31:0]               win_amt
);

   state_e           state, state_n;
   logic [2:0]       step, step_n;
   logic             issued, issued_n;
   logic [RND_W-1:0] rnd_cnt, rnd_n, rnd_q;
   logic [31:0]      key_q, x_q, y_q, z_q;
   logic [31:0]      cmd_data, data_n, win_n;
   logic [3:0]       op_n;
   logic [1:0]       fc_n;
   logic             start_n, busy_n, done_n, fail_n;
   logic             latch, tmo_load, tmo_exp;

   bids22_host_tmo #(.TMO_CYC(TMO_CYC), .TMO_W(TMO_W)) u_tmo (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (tmo_load),
      .expired (tmo_exp)
   );

   assign tmo_load = (state_n != state);

   // Data word for the current step from the shadowed configuration.
   always_comb begin
      cmd_data = key_q;
      case (step)
         3'd1:    cmd_data = x_q;
         3'd2:    cmd_data = y_q;
         3'd3:    cmd_data = z_q;
         default: cmd_data = key_q;
      endcase
   end

   // Next state and next values of every registered output.
   always_comb begin
      state_n  = state;
      step_n   = step;
      issued_n = 1'b0;
      rnd_n    = rnd_cnt;
      op_n     = NOOP;
      data_n   = '0;
      start_n  = bus.C_start;
      busy_n   = busy;
      done_n   = 1'b0;
      fail_n   = 1'b0;
      fc_n     = fail_code;
      win_n    = win_amt;
      latch    = 1'b0;
      case (state)
         S_IDLE: begin
            if (go) begin
               latch   = 1'b1;
               busy_n  = 1'b1;
               step_n  = 3'd0;
               fc_n    = FC_NONE;
               state_n = S_WAITRDY;
            end
         end
         S_WAITRDY: begin
            if (bus.ready) begin
               op_n    = step_op(step);
               data_n  = cmd_data;
               state_n = S_CHECK;
            end else if (tmo_exp) begin
               fc_n    = FC_RDYTMO;
               state_n = S_FAIL;
            end
         end
         S_CHECK: begin
            // First cycle is the issue cycle itself; err is judged one cycle later.
            if (!issued) begin
               issued_n = 1'b1;
            end else if (bus.err != '0) begin
               fc_n    = FC_CMDERR;
               state_n = S_FAIL;
            end else if (step == 3'd3) begin
               start_n = 1'b1;
               rnd_n   = (rnd_q == '0) ? RND_W'(1) : rnd_q;
               state_n = S_ROUND;
            end else if (step == 3'd4) begin
               state_n = S_DONE;
            end else begin
               step_n  = step + 3'd1;
               state_n = S_WAITRDY;
            end
         end
         S_ROUND: begin
            if (rnd_cnt <= RND_W'(1)) begin
               start_n = 1'b0;
               state_n = S_WAITOVER;
            end else begin
               rnd_n = rnd_cnt - RND_W'(1);
            end
         end
         S_WAITOVER: begin
            if (bus.roundOver) begin
               win_n   = bus.maxBid;
               step_n  = 3'd4;
               state_n = S_WAITRDY;
            end else if (tmo_exp) begin
               fc_n    = FC_OVERTMO;
               state_n = S_FAIL;
            end
         end
         S_DONE:  state_n = S_IDLE;
         S_FAIL:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      if (state_n == S_DONE) begin
         done_n = 1'b1;
         busy_n = 1'b0;
      end
      if (state_n == S_FAIL) begin
         fail_n  = 1'b1;
         busy_n  = 1'b0;
         start_n = 1'b0;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         step        <= '0;
         issued      <= 1'b0;
         rnd_cnt     <= '0;
         bus.C_op    <= NOOP;
         bus.C_data  <= '0;
         bus.C_start <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         fail        <= 1'b0;
         fail_code   <= FC_NONE;
         win_amt     <= '0;
      end else begin
         state       <= state_n;
         step        <= step_n;
         issued      <= issued_n;
         rnd_cnt     <= rnd_n;
         bus.C_op    <= op_n;
         bus.C_data  <= data_n;
         bus.C_start <= start_n;
         busy        <= busy_n;
         done        <= done_n;
         fail        <= fail_n;
         fail_code   <= fc_n;
         win_amt     <= win_n;
      end
   end

   // Configuration shadow captured on go so later cfg changes cannot disturb a run.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         key_q <= '0;
         x_q   <= '0;
         y_q   <= '0;
         z_q   <= '0;
         rnd_q <= '0;
      end else if (latch) begin
         key_q <= cfg_key;
         x_q   <= cfg_x_bal;
         y_q   <= cfg_y_bal;
         z_q   <= cfg_z_bal;
         rnd_q <= cfg_round_cycles;
      end
   end

endmodule

// File: tb/tb_bids22_ctrl_host.sv
// Directed bench for bids22_ctrl_host with a small core model and a command scoreboard.
`timescale 1ns/1ps
module tb_bids22_ctrl_host;

   localparam int unsigned TMO = 1024;
   localparam logic [3:0] OP_NOOP   = 4'd0;
   localparam logic [3:0] OP_UNLOCK = 4'd1;
   localparam logic [3:0] OP_LOCK   = 4'd2;
   localparam logic [3:0] OP_LOADX  = 4'd3;
   localparam logic [3:0] OP_LOADY  = 4'd4;
   localparam logic [3:0] OP_LOADZ  = 4'd5;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] data;
   } cmd_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        go;
   logic [31:0] cfg_key, cfg_x_bal, cfg_y_bal, cfg_z_bal;
   logic [15:0] cfg_round_cycles;
   logic        busy, done, fail;
   logic [1:0]  fail_code;
   logic [31:0] win_amt;

   bids22_ctrl_host_if bus();

   bids22_ctrl_host #(.RND_W(16), .TMO_CYC(TMO), .TMO_W(11)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .go               (go),
      .cfg_key          (cfg_key),
      .cfg_x_bal        (cfg_x_bal),
      .cfg_y_bal        (cfg_y_bal),
      .cfg_z_bal        (cfg_z_bal),
      .cfg_round_cycles (cfg_round_cycles),
      .bus              (bus),
      .busy             (busy),
      .done             (done),
      .fail             (fail),
      .fail_code        (fail_code),
      .win_amt          (win_amt)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   cmd_t exp_q[$];
   int   exp_len_q[$];
   cmd_t mon_e;

   // Core model knobs (written by the stimulus block only).
   logic [3:0]  err_op   = 4'd0;
   logic [2:0]  err_val  = 3'd0;
   logic [3:0]  stall_op = 4'd0;
   int          stall_len = 0;
   logic        ro_en    = 1'b1;
   int          ro_delay = 3;
   logic        early_ro = 1'b0;
   logic [31:0] late_bid = 32'd0;

   // Monitor/model state (written by the negedge process only).
   int          cyc = 0, run_len = 0, stall_cnt = 0, ro_cnt = 0;
   logic        prev_start = 1'b0, err_pend = 1'b0;
   logic [3:0]  prev_op = 4'd0;
   int          start_falls = 0, done_cnt = 0, fall_cyc = 0, fail_cyc = 0;
   int          loadx_cyc = 0, rdy_rise_cyc = 0, ready_fall_cyc = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Core model plus command/round monitor, all on the falling edge.
   always @(negedge clk) begin
      if (!reset_n) begin
         bus.ready     = 1'b1;
         bus.err       = 3'd0;
         bus.roundOver = 1'b0;
         bus.maxBid    = 32'd0;
         prev_start    = 1'b0;
         prev_op       = 4'd0;
         run_len       = 0;
         stall_cnt     = 0;
         ro_cnt        = 0;
         err_pend      = 1'b0;
      end else begin
         cyc++;
         bus.err  = err_pend ? err_val : 3'd0;
         err_pend = (err_op != OP_NOOP) && (bus.C_op == err_op);
         bus.roundOver = 1'b0;
         if (ro_cnt > 0) begin
            ro_cnt--;
            if (ro_cnt == 0) begin
               bus.roundOver = 1'b1;
               bus.maxBid    = late_bid;
            end
         end
         if (early_ro && bus.C_start) begin
            bus.roundOver = 1'b1;
            bus.maxBid    = 32'd999;
         end
         if (stall_cnt > 0) begin
            stall_cnt--;
            if (stall_cnt == 0) begin
               bus.ready    = 1'b1;
               rdy_rise_cyc = cyc;
            end
         end
         if (bus.C_op != OP_NOOP) begin
            check("cmd_single_cycle", prev_op, OP_NOOP);
            check("cmd_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("cmd_op", bus.C_op, mon_e.op);
               check("cmd_data", bus.C_data, mon_e.data);
            end
            if (bus.C_op == OP_LOADX) loadx_cyc = cyc;
            if (stall_op != OP_NOOP && bus.C_op == stall_op) begin
               stall_cnt      = stall_len;
               bus.ready      = 1'b0;
               ready_fall_cyc = cyc;
            end
         end else begin
            check("noop_data", bus.C_data, 0);
         end
         if (bus.C_start) begin
            run_len++;
         end else if (prev_start) begin
            start_falls++;
            fall_cyc = cyc;
            check("start_expected", exp_len_q.size() != 0, 1);
            if (exp_len_q.size() != 0) check("start_len", run_len, exp_len_q.pop_front());
            run_len = 0;
            if (ro_en) ro_cnt = ro_delay;
         end
         if (done) done_cnt++;
         if (fail) fail_cyc = cyc;
         prev_start = bus.C_start;
         prev_op    = bus.C_op;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [3:0] op, input logic [31:0] data);
      cmd_t c;
      c.op   = op;
      c.data = data;
      exp_q.push_back(c);
   endtask

   task automatic start_run(input logic [31:0] key, x, y, z, input logic [15:0] rc);
      cfg_key          = key;
      cfg_x_bal        = x;
      cfg_y_bal        = y;
      cfg_z_bal        = z;
      cfg_round_cycles = rc;
      @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      #1;
      cfg_key          = ~key;
      cfg_x_bal        = 32'hDEAD_0001;
      cfg_y_bal        = 32'hDEAD_0002;
      cfg_z_bal        = 32'hDEAD_0003;
      cfg_round_cycles = 16'd9;
   endtask

   task automatic wait_end(input int budget, input string tag);
      int n = 0;
      while (!(done || fail) && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check({tag, "_ended"}, done || fail, 1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_C_op"}, bus.C_op, 0);
      check({tag, "_C_data"}, bus.C_data, 0);
      check({tag, "_C_start"}, bus.C_start, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_fail"}, fail, 0);
      check({tag, "_fail_code"}, fail_code, 0);
      check({tag, "_win_amt"}, win_amt, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: observed no finish, expected finish before 400000ns");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, s0, n;
      reset_n = 1'b0;
      go = 1'b0;
      cfg_key = '0; cfg_x_bal = '0; cfg_y_bal = '0; cfg_z_bal = '0; cfg_round_cycles = '0;
      tick(3);
      check_reset_values("rst");
      @(negedge clk);
      reset_n = 1'b1;
      tick(2);

      // Nominal round.
      late_bid = 32'd150;
      push_cmd(OP_UNLOCK, 32'hA5A5_0001);
      push_cmd(OP_LOADX, 32'd100);
      push_cmd(OP_LOADY, 32'd200);
      push_cmd(OP_LOADZ, 32'd300);
      push_cmd(OP_LOCK, 32'hA5A5_0001);
      exp_len_q.push_back(5);
      d0 = done_cnt;
      start_run(32'hA5A5_0001, 32'd100, 32'd200, 32'd300, 16'd5);
      check("nom_busy", busy, 1);
      wait_end(300, "nom");
      check("nom_done", done, 1);
      check("nom_fail", fail, 0);
      check("nom_busy_end", busy, 0);
      check("nom_win", win_amt, 150);
      check("nom_code", fail_code, 0);
      tick(1);
      check("nom_done_pulse", done, 0);
      check("nom_cmd_q", exp_q.size(), 0);
      check("nom_len_q", exp_len_q.size(), 0);
      check("nom_done_cnt", done_cnt - d0, 1);

      // Command error after LOADY.
      err_op  = OP_LOADY;
      err_val = 3'b010;
      s0 = start_falls;
      push_cmd(OP_UNLOCK, 32'h0000_1234);
      push_cmd(OP_LOADX, 32'd7);
      push_cmd(OP_LOADY, 32'd8);
      start_run(32'h0000_1234, 32'd7, 32'd8, 32'd9, 16'd4);
      wait_end(300, "cerr");
      check("cerr_fail", fail, 1);
      check("cerr_code", fail_code, 1);
      check("cerr_busy", busy, 0);
      tick(6);
      check("cerr_fail_pulse", fail, 0);
      check("cerr_code_held", fail_code, 1);
      check("cerr_no_start", start_falls - s0, 0);
      check("cerr_cmd_q", exp_q.size(), 0);
      err_op = OP_NOOP;

      // Ready stall of 10 cycles before LOADX.
      stall_op  = OP_UNLOCK;
      stall_len = 10;
      late_bid  = 32'd42;
      push_cmd(OP_UNLOCK, 32'hBEEF_0002);
      push_cmd(OP_LOADX, 32'd11);
      push_cmd(OP_LOADY, 32'd22);
      push_cmd(OP_LOADZ, 32'd33);
      push_cmd(OP_LOCK, 32'hBEEF_0002);
      exp_len_q.push_back(2);
      start_run(32'hBEEF_0002, 32'd11, 32'd22, 32'd33, 16'd2);
      check("stall_code_clr", fail_code, 0);
      wait_end(300, "stall");
      check("stall_done", done, 1);
      check("stall_win", win_amt, 42);
      check("stall_loadx_lat", loadx_cyc - rdy_rise_cyc, 1);
      check("stall_cmd_q", exp_q.size(), 0);
      stall_op = OP_NOOP;
      tick(2);

      // Ready never returns within the timeout.
      stall_op  = OP_UNLOCK;
      stall_len = TMO + 50;
      push_cmd(OP_UNLOCK, 32'h0BAD_0003);
      start_run(32'h0BAD_0003, 32'd1, 32'd2, 32'd3, 16'd3);
      wait_end(TMO + 100, "rdytmo");
      check("rdytmo_fail", fail, 1);
      check("rdytmo_code", fail_code, 3);
      check("rdytmo_time", fail_cyc - ready_fall_cyc, TMO + 2);
      stall_op = OP_NOOP;
      n = 0;
      while (!bus.ready && n < 200) begin
         tick(1);
         n++;
      end
      check("rdytmo_ready_back", bus.ready, 1);
      check("rdytmo_cmd_q", exp_q.size(), 0);

      // roundOver never arrives.
      ro_en = 1'b0;
      push_cmd(OP_UNLOCK, 32'hC0DE_0004);
      push_cmd(OP_LOADX, 32'd5);
      push_cmd(OP_LOADY, 32'd6);
      push_cmd(OP_LOADZ, 32'd7);
      exp_len_q.push_back(3);
      start_run(32'hC0DE_0004, 32'd5, 32'd6, 32'd7, 16'd3);
      wait_end(TMO + 200, "rotmo");
      check("rotmo_fail", fail, 1);
      check("rotmo_code", fail_code, 2);
      check("rotmo_time", fail_cyc - fall_cyc, TMO);
      check("rotmo_start", bus.C_start, 0);
      tick(5);
      check("rotmo_cmd_q", exp_q.size(), 0);
      check("rotmo_len_q", exp_len_q.size(), 0);
      ro_en = 1'b1;

      // round_cycles=0, go while busy, roundOver during ROUND ignored.
      early_ro = 1'b1;
      late_bid = 32'd77;
      d0 = done_cnt;
      push_cmd(OP_UNLOCK, 32'h7777_0005);
      push_cmd(OP_LOADX, 32'd1000);
      push_cmd(OP_LOADY, 32'd2000);
      push_cmd(OP_LOADZ, 32'd3000);
      push_cmd(OP_LOCK, 32'h7777_0005);
      exp_len_q.push_back(1);
      start_run(32'h7777_0005, 32'd1000, 32'd2000, 32'd3000, 16'd0);
      tick(3);  go = 1'b1;
      tick(1);  go = 1'b0;
      tick(6);  go = 1'b1;
      tick(1);  go = 1'b0;
      tick(4);  go = 1'b1;
      tick(1);  go = 1'b0;
      wait_end(300, "edge");
      check("edge_done", done, 1);
      check("edge_win", win_amt, 77);
      tick(15);
      check("edge_single_done", done_cnt - d0, 1);
      check("edge_idle", busy, 0);
      check("edge_cmd_q", exp_q.size(), 0);
      check("edge_len_q", exp_len_q.size(), 0);
      early_ro = 1'b0;

      // Asynchronous reset in the middle of ROUND.
      push_cmd(OP_UNLOCK, 32'h5555_0006);
      push_cmd(OP_LOADX, 32'd4);
      push_cmd(OP_LOADY, 32'd5);
      push_cmd(OP_LOADZ, 32'd6);
      exp_len_q.push_back(20);
      start_run(32'h5555_0006, 32'd4, 32'd5, 32'd6, 16'd20);
      n = 0;
      while (!bus.C_start && n < 100) begin
         tick(1);
         n++;
      end
      check("arst_start_seen", bus.C_start, 1);
      tick(3);
      #2 reset_n = 1'b0;
      #1;
      check("arst_start_async", bus.C_start, 0);
      check("arst_busy_async", busy, 0);
      exp_q.delete();
      exp_len_q.delete();
      tick(2);
      check_reset_values("arst");
      @(negedge clk);
      reset_n = 1'b1;
      tick(5);
      check("arst_stays_idle", busy, 0);
      check("arst_no_start", bus.C_start, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
